fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the single-cycle core datapath and feeds it {instr, pc} pairs.
- Drives the instruction ROM, which has a registered 1-cycle read latency.
- Buffers fetched words in a small queue behind a valid/ready handshake.
- Accepts branch/jump redirects from execute and squashes wrong-path fetches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   INSTR_W          : instruction word width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP              : canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t    : {pc, instr} pair held in the instruction queue
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch_entry_t feeding the core.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears pointers and storage
//   flush_i : empty the queue; wins over push_i
//   push_i  : write entry_i at the tail (caller guarantees space)
//   entry_i : entry to write
//   pop_i   : drop the head entry (caller guarantees non-empty)
//   count_o : number of valid entries
//   head_o  : entry at the head (stale when count_o == 0)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  output logic [$clog2(QDEPTH+1)-1:0]  count_o,
  output fetch_entry_t                 head_o
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_entry_t mem_q [QDEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = ptr_next(wr_q);
      if (pop_i)  rd_d = ptr_next(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_q] <= entry_i;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a 1-cycle-latency instruction ROM, queues
// returned words with their PCs and hands them to the core over valid/ready.
// Redirects from execute flush the queue and drop the in-flight response.
//   clk_i            : clock, rising edge
//   rst_ni           : asynchronous active-low reset
//   imem_req_o       : ROM read strobe
//   imem_addr_o      : ROM word address (pc[ADDR_W+1:2])
//   imem_rdata_i     : ROM data, valid the cycle after imem_req_o
//   out_valid_o      : queue head holds a valid instruction
//   out_instr_o      : instruction at queue head
//   out_pc_o         : byte PC of out_instr_o
//   out_ready_i      : consumer accepts head this cycle
//   redirect_valid_i : execute requests a PC change
//   redirect_pc_i    : redirect target byte address (bits [1:0] ignored)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [31:0]        out_pc_o,
  input  logic               out_ready_i,
  input  logic               redirect_valid_i,
  input  logic [31:0]        redirect_pc_i
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_kill_q, inflight_kill_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;
  logic [31:0]   redir_pc;
  logic [31:0]   pc_sel;

  assign redir_pc = redirect_pc_i & ~32'h3;
  assign pc_sel   = redirect_valid_i ? redir_pc : fetch_pc_q;

  // Head is never handed over in a redirect cycle, so pop is naturally
  // suppressed while the queue is being flushed.
  assign out_valid_o = (count != '0) && !redirect_valid_i;
  assign pop         = out_valid_o && out_ready_i;

  // Entries held + word in flight - entry leaving now must leave room for
  // the word requested this cycle, so a response always has a slot.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = occupancy < (CW+1)'(QDEPTH);

  // A response landing in a redirect cycle belongs to the wrong path.
  assign push = inflight_q && !inflight_kill_q && !redirect_valid_i;

  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = imem_rdata_i;

  always_comb begin
    inflight_d      = issue;
    inflight_pc_d   = inflight_pc_q;
    // The request issued in any cycle is always on the current path (a
    // redirect in that cycle is what selected its address), so the kill
    // flag never needs to be raised at issue time.
    inflight_kill_d = 1'b0;
    fetch_pc_d      = fetch_pc_q;
    if (issue) begin
      inflight_pc_d = pc_sel;
      fetch_pc_d    = pc_sel + 32'd4;
    end else if (redirect_valid_i) begin
      fetch_pc_d    = redir_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_pc_q   <= '0;
      inflight_kill_q <= 1'b0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_pc_q   <= inflight_pc_d;
      inflight_kill_q <= inflight_kill_d;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head)
  );

  // Request path is combinational on the counters, so it is gated to keep
  // the ROM quiet while reset is held.
  assign imem_req_o  = issue && rst_ni;
  assign imem_addr_o = rst_ni ? pc_sel[ADDR_W+1:2] : '0;
  assign out_instr_o = head.instr;
  assign out_pc_o    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          ADDR_W   = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = 32'h0;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              out_ready = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .QDEPTH   (2),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (reset_n),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .out_valid_o      (out_valid),
    .out_instr_o      (out_instr),
    .out_pc_o         (out_pc),
    .out_ready_i      (out_ready),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc)
  );

  // ROM: word k holds 32'h1000_0000 + k, registered read.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'h1000_0000 + {24'h0, imem_addr};
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [7:0] k;
    k = pc[9:2];
    return 32'h1000_0000 + {24'h0, k};
  endfunction

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic        prev_hold;
  logic [31:0] prev_pc, prev_instr;
  int          gap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Abstract stream model: the consumer must see consecutive word PCs
  // starting at RESET_PC or at the latest redirect target.
  task automatic scoreboard();
    if (prev_hold && !redirect_valid) begin
      chk("bp_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_pc", out_pc, prev_pc);
      chk("bp_instr", out_instr, prev_instr);
    end
    if (redirect_valid) chk("redir_valid_low", {31'h0, out_valid}, 32'h0);
    if (!redirect_valid && !out_valid) gap++;
    else gap = 0;
    chk("starve_gap", {31'h0, gap > 4}, 32'h0);
    if (redirect_valid) begin
      exp_pc = redirect_pc & ~32'h3;
    end else if (out_valid && out_ready) begin
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_instr", out_instr, word_at(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    prev_hold  = out_valid && !out_ready && !redirect_valid;
    prev_pc    = out_pc;
    prev_instr = out_instr;
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    scoreboard();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset_n   = 1'b1;
    exp_pc    = RESET_PC;
    prev_hold = 1'b0;
    gap       = 0;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic        ereq;
    logic [7:0]  eaddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                     input logic ereq, input logic [7:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc;
    v.ein = ein; v.ereq = ereq; v.eaddr = eaddr;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_wrap;

    //  rdy rv  rpc           ev  epc         ein            req addr
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h00); // c0
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h01);
    add(0, 0, 32'h0,        1, 32'h0,    32'h1000_0000, 0, 8'h00); // stall
    add(0, 0, 32'h0,        1, 32'h0,    32'h1000_0000, 0, 8'h00);
    add(0, 0, 32'h0,        1, 32'h0,    32'h1000_0000, 0, 8'h00);
    add(0, 0, 32'h0,        1, 32'h0,    32'h1000_0000, 0, 8'h00);
    add(0, 0, 32'h0,        1, 32'h0,    32'h1000_0000, 0, 8'h00);
    add(1, 0, 32'h0,        1, 32'h0,    32'h1000_0000, 1, 8'h02); // release
    add(1, 0, 32'h0,        1, 32'h4,    32'h1000_0001, 1, 8'h03);
    add(1, 0, 32'h0,        1, 32'h8,    32'h1000_0002, 1, 8'h04);
    add(1, 1, 32'h40,       0, 32'h0,    32'h0,         0, 8'h00); // redirect, no room
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h10);
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h11);
    add(1, 0, 32'h0,        1, 32'h40,   32'h1000_0010, 1, 8'h12);
    add(1, 0, 32'h0,        1, 32'h44,   32'h1000_0011, 1, 8'h13);
    add(1, 1, 32'h40,       0, 32'h0,    32'h0,         0, 8'h00); // back-to-back
    add(1, 1, 32'h80,       0, 32'h0,    32'h0,         1, 8'h20);
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h21);
    add(1, 0, 32'h0,        1, 32'h80,   32'h1000_0020, 1, 8'h22);
    add(1, 0, 32'h0,        1, 32'h84,   32'h1000_0021, 1, 8'h23);
    add(1, 1, 32'h43,       0, 32'h0,    32'h0,         0, 8'h00); // misaligned
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h10);
    add(1, 1, 32'h400,      0, 32'h0,    32'h0,         1, 8'h00); // zero-bubble, alias
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h01);
    add(1, 0, 32'h0,        1, 32'h400,  32'h1000_0000, 1, 8'h02);
    add(1, 0, 32'h0,        1, 32'h404,  32'h1000_0001, 1, 8'h03);
    add(1, 1, 32'h43,       0, 32'h0,    32'h0,         0, 8'h00);
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h10);
    add(1, 0, 32'h0,        0, 32'h0,    32'h0,         1, 8'h11);
    add(1, 0, 32'h0,        1, 32'h40,   32'h1000_0010, 1, 8'h12);

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("t%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("t%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("t%0d_instr", i), out_instr, tbl[i].ein);
      end
      chk($sformatf("t%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].ereq});
      if (tbl[i].ereq) chk($sformatf("t%0d_addr", i), {24'h0, imem_addr}, {24'h0, tbl[i].eaddr});
    end

    // PC wrap past 32'hFFFF_FFFC.
    seen_wrap = 1'b0;
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (out_valid && out_pc == 32'h0) seen_wrap = 1'b1;
    end
    chk("wrap_seen", {31'h0, seen_wrap}, 32'h1);

    // Reset mid-stream with a word in flight; stale response must vanish.
    step(1'b1, 1'b0, 32'h0);
    chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    chk("rr_c0_valid", {31'h0, out_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("rr_c1_valid", {31'h0, out_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("rr_c2_valid", {31'h0, out_valid}, 32'h1);
    chk("rr_c2_pc", out_pc, RESET_PC);
    chk("rr_c2_instr", out_instr, 32'h1000_0000);

    // Randomised traffic against the stream model.
    for (int i = 0; i < 1500; i++) begin
      logic        rdy, rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      step(rdy, rv, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
